// File: rtl/z80_mem_pkg.sv
// Shared Z80 memory-path definitions: bus widths and the memory writer's state encoding.
// Used by mem_write_unit and the instruction fetch path.
package z80_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_STROBE = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

endpackage

// File: rtl/mem_write_unit.sv
// Byte-serial data-side memory writer: one 8/16-bit store (ascending or PUSH order) per request.
// 1 byte: finish 3 cycles after acceptance (+WAIT_STATES); dropping fsm_mw_en mid-write aborts cleanly.
module mem_write_unit
    import z80_mem_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fsm_mw_en,
    input  logic                  fsm_mw_two_byte,
    input  logic                  fsm_mw_stack,
    input  logic [ADDR_W-1:0]     fsm_mw_addr,
    input  logic [2*DATA_W-1:0]   fsm_mw_data,
    output logic [ADDR_W-1:0]     address_bus_mw,
    output logic [DATA_W-1:0]     data_output,
    output logic                  mem_wr,
    output logic                  mw_fsm_busy,
    output logic                  mw_fsm_finish,
    output logic [ADDR_W-1:0]     mw_fsm_sp
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    logic [1:0]            state;
    logic                  byte_idx;
    logic [2:0]            wait_cnt;
    logic [ADDR_W-1:0]     lat_addr;
    logic [2*DATA_W-1:0]   lat_data;
    logic                  lat_two;
    logic                  lat_stack;

    logic [1:0]            nxt_state;
    logic                  nxt_idx;
    logic [2:0]            nxt_cnt;
    logic                  nxt_drive;

    logic [ADDR_W-1:0]     cur_addr;
    logic [2*DATA_W-1:0]   cur_data;
    logic                  cur_two;
    logic                  cur_stack;

    // Ascending walks up from the base; stack mode pre-decrements below SP.
    function automatic logic [ADDR_W-1:0] step_addr(
        input logic [ADDR_W-1:0] base,
        input logic              stack,
        input logic              idx
    );
        logic [ADDR_W-1:0] ofs;
        ofs = {{(ADDR_W-1){1'b0}}, idx};
        return stack ? (base - ADDR_W'(1) - ofs) : (base + ofs);
    endfunction

    // Two-byte pushes emit the high byte first so it lands at SP-1.
    function automatic logic [DATA_W-1:0] byte_sel(
        input logic [2*DATA_W-1:0] data,
        input logic                two,
        input logic                stack,
        input logic                idx
    );
        return (idx ^ (two & stack)) ? data[2*DATA_W-1:DATA_W] : data[DATA_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] final_sp(
        input logic [ADDR_W-1:0] base,
        input logic              two,
        input logic              stack
    );
        return stack ? (base - (two ? ADDR_W'(2) : ADDR_W'(1))) : base;
    endfunction

    // On the accepting edge the latches are not loaded yet, so use the live request.
    always_comb begin
        cur_addr  = lat_addr;
        cur_data  = lat_data;
        cur_two   = lat_two;
        cur_stack = lat_stack;
        if (state == ST_IDLE) begin
            cur_addr  = fsm_mw_addr;
            cur_data  = fsm_mw_data;
            cur_two   = fsm_mw_two_byte;
            cur_stack = fsm_mw_stack;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = byte_idx;
        nxt_cnt   = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (fsm_mw_en) begin
                    nxt_state = ST_SETUP;
                    nxt_idx   = 1'b0;
                end
            end
            ST_SETUP: begin
                if (!fsm_mw_en) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_state = ST_STROBE;
                    nxt_cnt   = 3'd0;
                end
            end
            ST_STROBE: begin
                if (!fsm_mw_en) begin
                    nxt_state = ST_IDLE;
                end else if (wait_cnt == WS) begin
                    if (cur_two && !byte_idx) begin
                        nxt_state = ST_SETUP;
                        nxt_idx   = 1'b1;
                    end else begin
                        nxt_state = ST_DONE;
                    end
                end else begin
                    nxt_cnt = wait_cnt + 3'd1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
        nxt_drive = (nxt_state == ST_SETUP) || (nxt_state == ST_STROBE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            byte_idx  <= 1'b0;
            wait_cnt  <= 3'd0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_two   <= 1'b0;
            lat_stack <= 1'b0;
        end else begin
            state    <= nxt_state;
            byte_idx <= nxt_idx;
            wait_cnt <= nxt_cnt;
            if (state == ST_IDLE && fsm_mw_en) begin
                lat_addr  <= fsm_mw_addr;
                lat_data  <= fsm_mw_data;
                lat_two   <= fsm_mw_two_byte;
                lat_stack <= fsm_mw_stack;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address_bus_mw <= '0;
            data_output    <= '0;
            mem_wr         <= 1'b0;
            mw_fsm_busy    <= 1'b0;
            mw_fsm_finish  <= 1'b0;
            mw_fsm_sp      <= '0;
        end else begin
            address_bus_mw <= nxt_drive ? step_addr(cur_addr, cur_stack, nxt_idx) : '0;
            data_output    <= nxt_drive ? byte_sel(cur_data, cur_two, cur_stack, nxt_idx) : '0;
            mem_wr         <= (nxt_state == ST_STROBE);
            mw_fsm_busy    <= (nxt_state != ST_IDLE);
            mw_fsm_finish  <= (nxt_state == ST_DONE);
            mw_fsm_sp      <= (nxt_state == ST_DONE) ? final_sp(cur_addr, cur_two, cur_stack) : '0;
        end
    end

endmodule

// File: tb/tb_mem_write_unit.sv
// Bench for mem_write_unit: two instances (0 and 2 wait states) checked cycle by cycle
// against an expected output trace built from the byte map and latency rules.
module tb_mem_write_unit;

    localparam int WS1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en    [2];
    logic        two   [2];
    logic        stk   [2];
    logic [15:0] addr  [2];
    logic [15:0] data  [2];
    logic [15:0] abus  [2];
    logic [7:0]  dout  [2];
    logic        wr    [2];
    logic        busy  [2];
    logic        fin   [2];
    logic [15:0] sp    [2];

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q [$];
    logic [63:0] msk_q [$];

    // Field layout: {addr16, data8, wr, busy, finish, sp16}
    localparam logic [63:0] M_ALL  = {21'b0, 16'hFFFF, 8'hFF, 3'b111, 16'hFFFF};
    localparam logic [63:0] M_BYTE = {21'b0, 16'hFFFF, 8'hFF, 3'b111, 16'h0000};
    localparam logic [63:0] M_DONE = {21'b0, 16'h0000, 8'h00, 3'b111, 16'hFFFF};

    always #5 clk = ~clk;

    mem_write_unit #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .fsm_mw_en(en[0]), .fsm_mw_two_byte(two[0]), .fsm_mw_stack(stk[0]),
        .fsm_mw_addr(addr[0]), .fsm_mw_data(data[0]),
        .address_bus_mw(abus[0]), .data_output(dout[0]), .mem_wr(wr[0]),
        .mw_fsm_busy(busy[0]), .mw_fsm_finish(fin[0]), .mw_fsm_sp(sp[0])
    );

    mem_write_unit #(.WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset),
        .fsm_mw_en(en[1]), .fsm_mw_two_byte(two[1]), .fsm_mw_stack(stk[1]),
        .fsm_mw_addr(addr[1]), .fsm_mw_data(data[1]),
        .address_bus_mw(abus[1]), .data_output(dout[1]), .mem_wr(wr[1]),
        .mw_fsm_busy(busy[1]), .mw_fsm_finish(fin[1]), .mw_fsm_sp(sp[1])
    );

    function automatic logic [63:0] pk(input logic [15:0] a, input logic [7:0] d,
                                       input logic w, input logic b, input logic f,
                                       input logic [15:0] s);
        return {21'b0, a, d, w, b, f, s};
    endfunction

    function automatic logic [63:0] obs(input int s);
        return {21'b0, abus[s], dout[s], wr[s], busy[s], fin[s], sp[s]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Expected per-cycle outputs following the accepting edge, ending with the finish cycle.
    task automatic build_trace(input logic [15:0] a, input logic [15:0] d,
                               input bit tw, input bit st, input int ws);
        int nb;
        logic [15:0] ba;
        logic [7:0]  bd;
        exp_q.delete();
        msk_q.delete();
        nb = tw ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            ba = st ? (a - 16'(1 + b)) : (a + 16'(b));
            if (st && tw) bd = (b == 0) ? d[15:8] : d[7:0];
            else          bd = (b == 0) ? d[7:0]  : d[15:8];
            exp_q.push_back(pk(ba, bd, 1'b0, 1'b1, 1'b0, 16'h0));
            msk_q.push_back(M_BYTE);
            for (int w = 0; w <= ws; w++) begin
                exp_q.push_back(pk(ba, bd, 1'b1, 1'b1, 1'b0, 16'h0));
                msk_q.push_back(M_BYTE);
            end
        end
        exp_q.push_back(pk(16'h0, 8'h0, 1'b0, 1'b1, 1'b1, st ? (a - 16'(nb)) : a));
        msk_q.push_back(M_DONE);
    endtask

    // Caller is #1 after an edge with the DUT in an idle cycle.
    task automatic run_txn(input int s, input logic [15:0] a, input logic [15:0] d,
                           input bit tw, input bit st, input bit b2b,
                           input int abort_k, input string tag);
        int n;
        int last;
        build_trace(a, d, tw, st, (s == 0) ? 0 : WS1);
        n    = exp_q.size();
        last = (abort_k >= 0) ? abort_k : n - 1;
        en[s] = 1'b1; addr[s] = a; data[s] = d; two[s] = tw; stk[s] = st;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("%s[%0d]", tag, k), obs(s) & msk_q[k], exp_q[k] & msk_q[k]);
            addr[s] = 16'($urandom);
            data[s] = 16'($urandom);
            two[s]  = 1'($urandom);
            stk[s]  = 1'($urandom);
            if (k == abort_k)  en[s] = 1'b0;
            else if (k == n-1) en[s] = b2b;
        end
        @(posedge clk); #1;
        check_eq($sformatf("%s_idle", tag), obs(s), 64'h0);
    endtask

    initial begin
        int s, prev_s, ws, n, ak;
        bit tw, st, b2b, prev_b2b;
        logic [15:0] a, d;

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; two[i] = 1'b0; stk[i] = 1'b0; addr[i] = '0; data[i] = '0;
        end
        #12;
        check_eq("reset_dut0", obs(0), 64'h0);
        check_eq("reset_dut1", obs(1), 64'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset_idle", obs(0), 64'h0);

        // Reset asserted in the middle of the first strobe of a 2-byte write
        en[0] = 1'b1; addr[0] = 16'h1234; data[0] = 16'h5678; two[0] = 1'b1; stk[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_reset_strobe", obs(0) & M_BYTE, pk(16'h1234, 8'h78, 1'b1, 1'b1, 1'b0, 16'h0));
        #1 reset = 1'b0;
        #1 check_eq("async_reset_now", obs(0), 64'h0);
        en[0] = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("after_reset_%0d", i), obs(0), 64'h0);
        end

        run_txn(0, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, -1, "asc2");
        run_txn(0, 16'h0001, 16'hABCD, 1'b1, 1'b1, 1'b0, -1, "push_wrap");
        run_txn(0, 16'hFFFF, 16'h1122, 1'b1, 1'b0, 1'b0, -1, "asc_wrap");
        run_txn(0, 16'h0000, 16'h55EE, 1'b0, 1'b1, 1'b0, -1, "push1");
        run_txn(0, 16'h00FF, 16'h9933, 1'b0, 1'b0, 1'b0, -1, "asc1");
        run_txn(1, 16'h4000, 16'h0077, 1'b0, 1'b0, 1'b0, -1, "ws2_1b");
        run_txn(1, 16'h8000, 16'hC3D4, 1'b1, 1'b1, 1'b1, -1, "ws2_b2b_a");
        run_txn(1, 16'h8001, 16'h0102, 1'b1, 1'b0, 1'b0, -1, "ws2_b2b_b");
        run_txn(0, 16'h2000, 16'h3344, 1'b1, 1'b0, 1'b0, 2, "abort_setup2");
        run_txn(1, 16'h3000, 16'h5566, 1'b1, 1'b1, 1'b0, 3, "abort_strobe");

        prev_b2b = 1'b0;
        prev_s   = 0;
        for (int it = 0; it < 60; it++) begin
            s   = prev_b2b ? prev_s : int'($urandom_range(0, 1));
            ws  = (s == 0) ? 0 : WS1;
            a   = 16'($urandom);
            d   = 16'($urandom);
            tw  = 1'($urandom);
            st  = 1'($urandom);
            if ($urandom_range(0, 3) == 0) a = st ? 16'($urandom_range(0, 1)) : 16'hFFFF;
            n   = (tw ? 2 : 1) * (2 + ws) + 1;
            ak  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 2)) : -1;
            b2b = (ak < 0) && ($urandom_range(0, 2) == 0);
            run_txn(s, a, d, tw, st, b2b, ak, $sformatf("rnd%0d", it));
            if (!b2b) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    @(posedge clk); #1;
                    check_eq($sformatf("rnd%0d_gap", it), obs(s), 64'h0);
                end
            end
            prev_b2b = b2b;
            prev_s   = s;
        end
        if (prev_b2b) begin
            en[prev_s] = 1'b0;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
